ram_arbiter_2p: RTL and testbench

//  Round-robin arbiter/sequencer sharing one single-port synchronous RAM (1-cycle registered read,

---
 rtl/ram_arbiter_2p_pkg.sv | 20 ++
 rtl/ram_arbiter_2p_rr.sv | 29 ++
 rtl/ram_arbiter_2p.sv | 152 +++++++++++++++
 tb/tb_ram_arbiter_2p.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_2p_pkg.sv
// ram_arbiter_2p_pkg
//   Shared definitions for the two-port RAM arbiter: FSM state encoding,
//   default address/data widths and a small port-index helper.
package ram_arbiter_2p_pkg;

  localparam int AW_DEFAULT = 10;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // Port index (0/1) to one-hot request/grant vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_2p_rr.sv
// rr_arbiter_2
//   Purely combinational two-way round-robin pick. The "last" pointer is
//   owned by the caller; this block only decides who wins this arbitration.
// Ports
//   req_i    [1:0] in   eligible requests (already masked by the caller)
//   last_i         in   port that won the previous arbitration
//   any_o          out  at least one eligible request
//   winner_o       out  winning port index (0/1), meaningful when any_o=1
module rr_arbiter_2
  import ram_arbiter_2p_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       winner_o
);

  always_comb begin
    any_o    = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;  // tie goes to the port that did not win last
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
//   Shares one single-port synchronous RAM (1-cycle registered read) between
//   two requesters. The winning command is latched straight into the RAM port
//   registers, driven for one ISSUE cycle, and read data is returned one cycle
//   later with a per-port valid strobe.
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req{0,1}_i                   request, held with we/addr/din until gnt
//   we{0,1}_i                    1=write, 0=read
//   addr{0,1}_i [AW-1:0]         access address
//   din{0,1}_i  [DW-1:0]         write data
//   gnt{0,1}_o                   one-cycle pulse in ISSUE: command accepted
//   rvalid{0,1}_o                one-cycle pulse: rdata_o holds read result
//   rdata_o     [DW-1:0]         shared read data (= ram_dout_i)
//   busy_o                       FSM not idle
//   ram_cs_o, ram_we_o           RAM chip select / write enable
//   ram_addr_o, ram_din_o        RAM address / write data
//   ram_dout_i  [DW-1:0]         RAM read data
module ram_arbiter_2p
  import ram_arbiter_2p_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] din0_i,
  input  logic [DW-1:0] din1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          rvalid0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
  output logic          ram_cs_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_din_o,
  input  logic [DW-1:0] ram_dout_i
);

  state_e        state_q;
  logic          winner_q;
  logic          last_q;
  logic [1:0]    gnt_q;
  logic [1:0]    rvalid_q;
  logic          ram_cs_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;

  logic [1:0]    req_elig;
  logic          arb_any;
  logic          arb_winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;

  // While a port is being granted its req line still shows the command just
  // accepted; mask it so the same command is not taken twice.
  always_comb begin
    req_elig = {req1_i, req0_i};
    if (state_q == S_ISSUE) begin
      req_elig = req_elig & ~port_onehot(winner_q);
    end
  end

  rr_arbiter_2 u_rr (
    .req_i    (req_elig),
    .last_i   (last_q),
    .any_o    (arb_any),
    .winner_o (arb_winner)
  );

  assign sel_we   = arb_winner ? we1_i   : we0_i;
  assign sel_addr = arb_winner ? addr1_i : addr0_i;
  assign sel_din  = arb_winner ? din1_i  : din0_i;

  // The RAM port registers double as the command latch: everything the
  // ISSUE cycle needs is captured at the arbitration edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      ram_cs_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        S_ISSUE: begin
          if (!ram_we_q) begin
            // Read: RAM registers the data at this edge, respond next cycle.
            state_q  <= S_RESP;
            rvalid_q <= port_onehot(winner_q);
          end else if (arb_any) begin
            state_q    <= S_ISSUE;
            winner_q   <= arb_winner;
            last_q     <= arb_winner;
            gnt_q      <= port_onehot(arb_winner);
            ram_cs_q   <= 1'b1;
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          // IDLE and RESP (and any illegal code) arbitrate over both ports.
          if (arb_any) begin
            state_q    <= S_ISSUE;
            winner_q   <= arb_winner;
            last_q     <= arb_winner;
            gnt_q      <= port_onehot(arb_winner);
            ram_cs_q   <= 1'b1;
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt0_o     = gnt_q[0];
  assign gnt1_o     = gnt_q[1];
  assign rvalid0_o  = rvalid_q[0];
  assign rvalid1_o  = rvalid_q[1];
  assign busy_o     = (state_q != S_IDLE);
  assign ram_cs_o   = ram_cs_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign rdata_o    = ram_dout_i;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p
//   Drives ram_arbiter_2p together with a single-port RAM model. Directed
//   scenarios plus a randomized two-requester run scored against a
//   transaction-level model (golden memory + round-robin grant rules).
module tb_ram_arbiter_2p;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, rdata;
  wire  [DW-1:0] ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] gmem [1024];

  always #5 clk = ~clk;

  ram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req0_i     (req0),
    .req1_i     (req1),
    .we0_i      (we0),
    .we1_i      (we1),
    .addr0_i    (addr0),
    .addr1_i    (addr1),
    .din0_i     (din0),
    .din1_i     (din1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .rvalid0_o  (rvalid0),
    .rvalid1_o  (rvalid1),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .ram_cs_o   (ram_cs),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  // Single-port RAM model: registered read, output floats when not selected
  // on the previous edge.
  logic          init_en;
  logic [DW-1:0] ram_mem [1024];
  logic [DW-1:0] ram_q;
  logic          ram_oe;

  function automatic logic [DW-1:0] pat(input int i);
    return 8'((i * 37) ^ (i >> 3) ^ 8'h5A);
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= pat(i);
      ram_oe <= 1'b0;
    end else begin
      ram_oe <= ram_cs;
      if (ram_cs) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        else        ram_q <= ram_mem[ram_addr];
      end
    end
  end

  assign ram_dout = ram_oe ? ram_q : 'z;

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [AW-1:0] pick_addr(input int k);
    case (k)
      0: return 10'h000;
      1: return 10'h001;
      2: return 10'h3FF;
      3: return 10'h3FE;
      4: return 10'h200;
      5: return 10'h155;
      6: return 10'h0AA;
      default: return 10'h013;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_port(input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; din0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; din1 = d; end
  endtask

  task automatic idle_inputs();
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Issues one read on port p and waits (bounded) for its response.
  task automatic read_port(input int p, input logic [AW-1:0] a,
                           output logic [DW-1:0] d, output logic ok);
    logic done;
    ok = 1'b0; d = '0; done = 1'b0;
    drive_port(p, 1'b1, 1'b0, a, '0);
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if ((p == 0) ? gnt0 : gnt1) begin
        done = 1'b1;
        drive_port(p, 1'b0, 1'b0, a, '0);
        step();
        if ((p == 0) ? rvalid0 : rvalid1) begin d = rdata; ok = 1'b1; end
      end
    end
    drive_port(p, 1'b0, 1'b0, a, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_cs, ram_we} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected %b",
                        {gnt0, gnt1, rvalid0, rvalid1, busy, ram_cs, ram_we}, 7'b0);
    end
    n_cmp++;
    if ({ram_addr, ram_din} !== 18'b0) begin
      n_err++; $display("FAIL reset_bus: got %h expected %h", {ram_addr, ram_din}, 18'h0);
    end
    rst = 1'b0;
    step();
    $display("txn reset done");
  endtask

  task automatic test_write_read();
    do_reset();
    drive_port(0, 1'b1, 1'b1, 10'h005, 8'hA5);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_err++; $display("FAIL t1_wr_gnt: got %b expected %b", {gnt1, gnt0}, 2'b01);
    end
    n_cmp++;
    if ({ram_cs, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 10'h005, 8'hA5}) begin
      n_err++; $display("FAIL t1_wr_port: got %h expected %h",
                        {ram_cs, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 10'h005, 8'hA5});
    end
    gmem[10'h005] = 8'hA5;
    drive_port(0, 1'b0, 1'b0, 10'h005, 8'h00);
    step();
    n_cmp++;
    if ({gnt0, busy} !== 2'b00) begin
      n_err++; $display("FAIL t1_idle: got %b expected %b", {gnt0, busy}, 2'b00);
    end
    drive_port(0, 1'b1, 1'b0, 10'h005, 8'h00);
    step();
    n_cmp++;
    if ({gnt1, gnt0, ram_cs, ram_we} !== 4'b0110) begin
      n_err++; $display("FAIL t1_rd_gnt: got %b expected %b", {gnt1, gnt0, ram_cs, ram_we}, 4'b0110);
    end
    drive_port(0, 1'b0, 1'b0, 10'h005, 8'h00);
    step();
    n_cmp++;
    if ({rvalid1, rvalid0} !== 2'b01 || rdata !== gmem[10'h005]) begin
      n_err++; $display("FAIL t1_rd_data: got rv=%b rdata=%h expected rv=01 rdata=%h",
                        {rvalid1, rvalid0}, rdata, gmem[10'h005]);
    end
    step();
    n_cmp++;
    if ({rvalid1, rvalid0} !== 2'b00) begin
      n_err++; $display("FAIL t1_rv_pulse: got %b expected %b", {rvalid1, rvalid0}, 2'b00);
    end
    $display("txn write/read port0 addr=005 done");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic ok;
    do_reset();
    drive_port(0, 1'b1, 1'b1, 10'h010, 8'h11);
    drive_port(1, 1'b1, 1'b1, 10'h020, 8'h22);
    step();
    n_cmp++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      n_err++; $display("FAIL t2_first: got %b expected %b", {gnt0, gnt1, busy}, 3'b101);
    end
    gmem[10'h010] = 8'h11;
    drive_port(0, 1'b0, 1'b0, 10'h010, 8'h11);
    step();
    n_cmp++;
    if ({gnt0, gnt1, busy} !== 3'b011) begin
      n_err++; $display("FAIL t2_second: got %b expected %b", {gnt0, gnt1, busy}, 3'b011);
    end
    gmem[10'h020] = 8'h22;
    drive_port(1, 1'b0, 1'b0, 10'h020, 8'h22);
    step();
    n_cmp++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      n_err++; $display("FAIL t2_done: got %b expected %b", {gnt0, gnt1, busy}, 3'b000);
    end
    read_port(0, 10'h010, d, ok);
    n_cmp++;
    if (!ok || d !== gmem[10'h010]) begin
      n_err++; $display("FAIL t2_rb0: got ok=%b %h expected %h", ok, d, gmem[10'h010]);
    end
    read_port(1, 10'h020, d, ok);
    n_cmp++;
    if (!ok || d !== gmem[10'h020]) begin
      n_err++; $display("FAIL t2_rb1: got ok=%b %h expected %h", ok, d, gmem[10'h020]);
    end
    $display("txn back-to-back writes done");
  endtask

  task automatic test_alternating_reads();
    logic [AW-1:0] a [2];
    logic [DW-1:0] exp_d;
    logic [1:0]    eg, erv;
    do_reset();
    exp_d = '0;
    for (int p = 0; p < 2; p++) begin
      a[p] = 10'($urandom_range(0, 1023));
      drive_port(p, 1'b1, 1'b0, a[p], '0);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      eg  = (k % 2 == 0) ? oh((k / 2) % 2) : 2'b00;
      erv = (k % 2 == 1) ? oh(((k - 1) / 2) % 2) : 2'b00;
      n_cmp++;
      if ({gnt1, gnt0} !== eg) begin
        n_err++; $display("FAIL t3_gnt k=%0d: got %b expected %b", k, {gnt1, gnt0}, eg);
      end
      n_cmp++;
      if ({rvalid1, rvalid0} !== erv) begin
        n_err++; $display("FAIL t3_rv k=%0d: got %b expected %b", k, {rvalid1, rvalid0}, erv);
      end
      if (erv != 2'b00) begin
        n_cmp++;
        if (rdata !== exp_d) begin
          n_err++; $display("FAIL t3_data k=%0d: got %h expected %h", k, rdata, exp_d);
        end
      end
      if (eg != 2'b00) exp_d = gmem[a[(k / 2) % 2]];
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? gnt0 : gnt1) begin
          a[p] = 10'($urandom_range(0, 1023));
          drive_port(p, 1'b1, 1'b0, a[p], '0);
        end
      end
      if (k == 15) idle_inputs();
    end
    step();
    n_cmp++;
    if ({gnt1, gnt0, busy} !== 3'b000) begin
      n_err++; $display("FAIL t3_drain: got %b expected %b", {gnt1, gnt0, busy}, 3'b000);
    end
    $display("txn alternating reads x8 done");
  endtask

  task automatic test_withdraw();
    logic [DW-1:0] d;
    logic ok;
    int cnt;
    cnt = 0;
    drive_port(0, 1'b1, 1'b0, 10'h0C0, '0);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_err++; $display("FAIL t4_gnt0: got %b expected %b", {gnt1, gnt0}, 2'b01);
    end
    drive_port(0, 1'b0, 1'b0, 10'h0C0, '0);
    drive_port(1, 1'b1, 1'b1, 10'h0B0, ~gmem[10'h0B0]);
    step();
    n_cmp++;
    if ({gnt1, rvalid1, rvalid0} !== 3'b001 || rdata !== gmem[10'h0C0]) begin
      n_err++; $display("FAIL t4_resp: got %b/%h expected 001/%h",
                        {gnt1, rvalid1, rvalid0}, rdata, gmem[10'h0C0]);
    end
    drive_port(1, 1'b0, 1'b0, 10'h0B0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(gnt1) + int'(ram_cs);
    end
    n_cmp++;
    if (cnt != 0) begin
      n_err++; $display("FAIL t4_no_access: got %0d expected %0d", cnt, 0);
    end
    read_port(1, 10'h0B0, d, ok);
    n_cmp++;
    if (!ok || d !== gmem[10'h0B0]) begin
      n_err++; $display("FAIL t4_unchanged: got ok=%b %h expected %h", ok, d, gmem[10'h0B0]);
    end
    $display("txn withdrawn request done");
  endtask

  task automatic test_async_reset();
    logic got;
    do_reset();
    drive_port(1, 1'b1, 1'b0, 10'h2A1, '0);
    step();
    n_cmp++;
    if ({gnt1, gnt0, ram_addr} !== {2'b10, 10'h2A1}) begin
      n_err++; $display("FAIL t5_gnt1: got %h expected %h", {gnt1, gnt0, ram_addr}, {2'b10, 10'h2A1});
    end
    drive_port(1, 1'b0, 1'b0, 10'h2A1, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_cs, ram_we, ram_addr, ram_din} !== 25'b0) begin
      n_err++; $display("FAIL t5_async: got %h expected %h",
                        {gnt0, gnt1, rvalid0, rvalid1, busy, ram_cs, ram_we, ram_addr, ram_din}, 25'h0);
    end
    step();
    n_cmp++;
    if ({rvalid1, busy} !== 2'b00) begin
      n_err++; $display("FAIL t5_lost: got %b expected %b", {rvalid1, busy}, 2'b00);
    end
    rst = 1'b0;
    drive_port(0, 1'b1, 1'b0, 10'h0E0, '0);
    drive_port(1, 1'b1, 1'b0, 10'h0E1, '0);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_err++; $display("FAIL t5_tie: got %b expected %b", {gnt1, gnt0}, 2'b01);
    end
    drive_port(0, 1'b0, 1'b0, 10'h0E0, '0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (gnt1) begin got = 1'b1; drive_port(1, 1'b0, 1'b0, 10'h0E1, '0); end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL t5_gnt1_timeout: got %b expected %b", got, 1'b1);
    end
    idle_inputs();
    step();
    step();
    $display("txn async reset during RESP done");
  endtask

  task automatic test_top_address();
    drive_port(1, 1'b1, 1'b1, 10'h3FF, 8'h5C);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b10) begin
      n_err++; $display("FAIL t6_wgnt: got %b expected %b", {gnt1, gnt0}, 2'b10);
    end
    gmem[10'h3FF] = 8'h5C;
    drive_port(1, 1'b0, 1'b0, 10'h3FF, 8'h00);
    drive_port(0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    step();
    n_cmp++;
    if ({gnt1, gnt0, ram_we, ram_addr} !== {3'b010, 10'h3FF}) begin
      n_err++; $display("FAIL t6_rgnt: got %h expected %h", {gnt1, gnt0, ram_we, ram_addr}, {3'b010, 10'h3FF});
    end
    drive_port(0, 1'b0, 1'b0, 10'h3FF, 8'h00);
    step();
    n_cmp++;
    if ({rvalid1, rvalid0} !== 2'b01 || rdata !== gmem[10'h3FF]) begin
      n_err++; $display("FAIL t6_data: got rv=%b %h expected rv=01 %h", {rvalid1, rvalid0}, rdata, gmem[10'h3FF]);
    end
    step();
    $display("txn cross-port top-address write/read done");
  endtask

  // Random traffic. The model works on transactions: a grant cycle for a
  // read is followed by a response cycle with no grant; a port granted in
  // one cycle cannot be granted the next; on a tie the port other than the
  // previously granted one wins; memory contents follow grant order.
  task automatic test_random_traffic();
    int            last_g, prev_gp, egp, rv_p;
    logic [1:0]    req_prev, elig, eg, erv;
    logic          prev_gv, prev_gwe, arb, egv, rv_v;
    logic [DW-1:0] rv_d;
    logic          pend [2];
    logic          cwe  [2];
    logic [AW-1:0] ca   [2];
    logic [DW-1:0] cd   [2];
    do_reset();
    last_g = 1; prev_gp = 0; rv_p = 0; req_prev = 2'b00;
    prev_gv = 1'b0; prev_gwe = 1'b0; rv_v = 1'b0; rv_d = '0;
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; cwe[p] = 1'b0; ca[p] = '0; cd[p] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      arb  = !(prev_gv && !prev_gwe);
      elig = req_prev;
      if (prev_gv) elig[prev_gp] = 1'b0;
      egv  = arb && (elig != 2'b00);
      egp  = (elig == 2'b11) ? (1 - last_g) : (elig[1] ? 1 : 0);
      eg   = egv ? oh(egp) : 2'b00;
      erv  = rv_v ? oh(rv_p) : 2'b00;
      n_cmp++;
      if ({gnt1, gnt0} !== eg) begin
        n_err++; $display("FAIL rnd_gnt cyc=%0d: got %b expected %b", cyc, {gnt1, gnt0}, eg);
      end
      n_cmp++;
      if ({rvalid1, rvalid0} !== erv) begin
        n_err++; $display("FAIL rnd_rv cyc=%0d: got %b expected %b", cyc, {rvalid1, rvalid0}, erv);
      end
      if (rv_v) begin
        n_cmp++;
        if (rdata !== rv_d) begin
          n_err++; $display("FAIL rnd_data cyc=%0d: got %h expected %h", cyc, rdata, rv_d);
        end
      end
      if (egv) begin
        n_cmp++;
        if ({ram_cs, ram_we, ram_addr} !== {1'b1, cwe[egp], ca[egp]}) begin
          n_err++; $display("FAIL rnd_cmd cyc=%0d: got %h expected %h",
                            cyc, {ram_cs, ram_we, ram_addr}, {1'b1, cwe[egp], ca[egp]});
        end
        if (cwe[egp]) begin
          n_cmp++;
          if (ram_din !== cd[egp]) begin
            n_err++; $display("FAIL rnd_din cyc=%0d: got %h expected %h", cyc, ram_din, cd[egp]);
          end
          gmem[ca[egp]] = cd[egp];
        end
        $display("txn cyc=%0d port=%0d we=%0d addr=%h din=%h", cyc, egp, cwe[egp], ca[egp], cd[egp]);
        last_g = egp;
        pend[egp] = 1'b0;
      end
      rv_v = egv && !cwe[egp];
      rv_p = egp;
      if (rv_v) rv_d = gmem[ca[egp]];
      prev_gv  = egv;
      prev_gp  = egp;
      prev_gwe = cwe[egp];
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && $urandom_range(0, 15) == 0) begin
          pend[p] = 1'b0;
        end else if (!pend[p] && cyc < 390 && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          cwe[p]  = 1'($urandom_range(0, 1));
          ca[p]   = pick_addr(int'($urandom_range(0, 7)));
          cd[p]   = 8'($urandom_range(0, 255));
        end
        drive_port(p, pend[p], cwe[p], ca[p], cd[p]);
      end
      req_prev = {pend[1], pend[0]};
    end
    idle_inputs();
    step();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    init_en = 1'b1;
    idle_inputs();
    for (int i = 0; i < 1024; i++) gmem[i] = pat(i);
    step();
    init_en = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_alternating_reads();
    test_withdraw();
    test_async_reset();
    test_top_address();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
